shuffle_ctrl: RTL and testbench
===============================

SHUFFLE_CTRL -- requirements
Module: shuffle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request one shuffle pass; sampled in IDLE only.
REQ-004 SHALL have port: seed_load  input  1  load seed into LFSR; honoured in IDLE only.
REQ-005 SHALL have port: seed  input  8  LFSR seed value.
REQ-006 SHALL have port: init  output  1  drives downstream permutation-register init (identity 0..7).
REQ-007 SHALL have port: swapxy  output  1  downstream swap strobe; swaps entries x and y that cycle.
REQ-008 SHALL have port: x  output  3  swap index i (upper position).
REQ-009 SHALL have port: y  output  3  swap index j (random position, j <= i).
REQ-010 SHALL have port: busy  output  1  high in INIT and SWAP.
REQ-011 SHALL have port: done  output  1  one-cycle pulse at pass completion.
REQ-012 SHALL drive all outputs from registered state (state, i, lfsr, rej count) only; no input-to-output combinational path.

Function
REQ-013 SHALL implement FSM states IDLE, INIT, SWAP, DONE.
REQ-014 IDLE: start=1 -> INIT next cycle; seed_load=1 -> lfsr<=seed (8'h00 replaced by 8'h01); seed_load and start together: both act.
REQ-015 INIT: init=1 for exactly one cycle; i<=7, rej<=0; next state SWAP.
REQ-016 SWAP: j=lfsr[2:0]; if j<=i, accept: swapxy=1, x=i, y=j, i<=i-1, rej<=0; else reject: swapxy=0, rej<=rej+1.
REQ-017 SWAP: lfsr advances every SWAP cycle (accept or reject), nowhere else except seed load.
REQ-018 LFSR SHALL shift left, bit0 <= lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] (maximal length, period 255).
REQ-019 Accept with i=1 -> DONE next cycle; exactly 7 accepted swaps per pass (i=7..1).
REQ-020 DONE: done=1 for one cycle, next state IDLE.
REQ-021 start, seed_load in INIT/SWAP/DONE SHALL be ignored (no queueing).
REQ-022 When swapxy=0, x and y SHALL be 0; init and swapxy never high together.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, lfsr=8'h01, i=0, rej=0; all outputs 0.
REQ-024 Reset mid-pass SHALL abandon the pass; no done pulse; first pass after release starts from INIT.

Configuration
REQ-025 Macro SHUFFLE_BOUNDED_EN: when defined, after 4 consecutive rejections the next SWAP cycle SHALL accept unconditionally with y=i (swapxy=1, x=y=i); each step then takes at most 5 cycles.
REQ-026 Without SHUFFLE_BOUNDED_EN, rejection continues until j<=i (unbounded in principle, bounded by LFSR period); rej counter may be omitted.

Verification
REQ-027 Reset, seed 8'h01 default, start -> init 1 cycle, then accepts (x,y)=(7,1),(6,2),(5,4),(4,0),(3,1) on consecutive cycles.
REQ-028 Same run, i=2: lfsr 23,47,8E,1C rejected (swapxy=0 four cycles); next cycle (lfsr 38): without macro (x,y)=(2,0), with SHUFFLE_BOUNDED_EN (x,y)=(2,2).
REQ-029 seed_load with seed=8'h00 in IDLE, then start -> behaves identically to seed 8'h01 (REQ-027 sequence).
REQ-030 start pulsed during SWAP -> ignored; exactly 7 swapxy pulses, one done pulse, then IDLE with busy=0.
REQ-031 rst_n asserted mid-SWAP -> outputs 0 asynchronously, no done; restart reproduces REQ-027 sequence.
REQ-032 Downstream model check: after done, permutation of 0..7 contains each value exactly once.

Source files
------------

// File: rtl/shuffle_ctrl.sv
// shuffle_ctrl: sequencer for an in-place Fisher-Yates shuffle of an external
// 8-entry permutation register. It emits one init strobe, then seven accepted
// swap strobes (x = 7 down to 1, y = random index <= x), then a done pulse.
// Random indices come from an 8-bit maximal-length LFSR that advances once per
// SWAP cycle and otherwise holds its value across passes.
// Optional build macro: SHUFFLE_BOUNDED_EN. When it is defined, four
// consecutive rejections force the following SWAP cycle to accept with y = x.
module shuffle_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       seed_load,
  input  logic [7:0] seed,
  output logic       init,
  output logic       swapxy,
  output logic [2:0] x,
  output logic [2:0] y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, INIT, SWAP, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] lfsr, lfsr_nxt;
  logic       accept_now, forced_now;
  logic       accept_nxt, forced_nxt;
`ifdef SHUFFLE_BOUNDED_EN
  logic [2:0] rej, rej_nxt;
`endif

  // Shift left, feedback taps 8,6,5,4 give the full 255-state cycle.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Accept decision for the current cycle and for the upcoming cycle; the
  // upcoming one feeds the output registers so they line up with the state.
  always_comb begin
`ifdef SHUFFLE_BOUNDED_EN
    forced_now = (rej == 3'd4);
    forced_nxt = (rej_nxt == 3'd4);
`else
    forced_now = 1'b0;
    forced_nxt = 1'b0;
`endif
    accept_now = forced_now || (lfsr[2:0] <= idx);
    accept_nxt = forced_nxt || (lfsr_nxt[2:0] <= idx_nxt);
  end

  // Next-state and datapath update rules for every FSM state.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    lfsr_nxt  = lfsr;
`ifdef SHUFFLE_BOUNDED_EN
    rej_nxt   = rej;
`endif
    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_nxt = (seed == 8'h00) ? 8'h01 : seed;
        end
        if (start) begin
          state_nxt = INIT;
        end
      end
      INIT: begin
        idx_nxt   = 3'd7;
`ifdef SHUFFLE_BOUNDED_EN
        rej_nxt   = 3'd0;
`endif
        state_nxt = SWAP;
      end
      SWAP: begin
        lfsr_nxt = lfsr_step(lfsr);
        if (accept_now) begin
          idx_nxt = idx - 3'd1;
`ifdef SHUFFLE_BOUNDED_EN
          rej_nxt = 3'd0;
`endif
          if (idx == 3'd1) begin
            state_nxt = DONE;
          end
        end else begin
`ifdef SHUFFLE_BOUNDED_EN
          rej_nxt = rej + 3'd1;
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers plus registered outputs computed from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 3'd0;
      lfsr   <= 8'h01;
`ifdef SHUFFLE_BOUNDED_EN
      rej    <= 3'd0;
`endif
      init   <= 1'b0;
      swapxy <= 1'b0;
      x      <= 3'd0;
      y      <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      lfsr   <= lfsr_nxt;
`ifdef SHUFFLE_BOUNDED_EN
      rej    <= rej_nxt;
`endif
      init   <= (state_nxt == INIT);
      busy   <= (state_nxt == INIT) || (state_nxt == SWAP);
      done   <= (state_nxt == DONE);
      if ((state_nxt == SWAP) && accept_nxt) begin
        swapxy <= 1'b1;
        x      <= idx_nxt;
        y      <= forced_nxt ? idx_nxt : lfsr_nxt[2:0];
      end else begin
        swapxy <= 1'b0;
        x      <= 3'd0;
        y      <= 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_shuffle_ctrl.sv
// tb_shuffle_ctrl: directed bench for shuffle_ctrl. A pass-level model
// expands each started pass into the expected per-cycle output records, and a
// single compare process checks every cycle against it (all-zero when idle).
// Literal swap sequences for seed 8'h01 pin the model.
module tb_shuffle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic       init, swapxy, busy, done;
  logic [2:0] x, y;

  shuffle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .init      (init),
    .swapxy    (swapxy),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done)
  );

`ifdef SHUFFLE_BOUNDED_EN
  localparam bit BOUNDED = 1'b1;
`else
  localparam bit BOUNDED = 1'b0;
`endif

  typedef logic [9:0] rec_t;  // {init, swapxy, x, y, busy, done}

  int          checks = 0;
  int          passed = 0;
  rec_t        exp_q[$];
  logic [7:0]  model_lfsr = 8'h01;
  int          model_perm[8];
  int          dut_perm[8];
  int          swap_log[$];
  int          done_count = 0;
  int          reject_count = 0;
  int          lit[7];

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  function automatic rec_t mk(bit i, bit s, int xx, int yy, bit b, bit d);
    logic [2:0] xv, yv;
    xv = xx[2:0];
    yv = yy[2:0];
    return {i, s, xv, yv, b, d};
  endfunction

  function automatic logic [7:0] model_step(logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic checkOutput(string name, int actual, int required);
    checks++;
    if (actual == required) passed++;
    else $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
  endtask

  // Expand one pass into expected cycle records and the expected final permutation.
  task automatic buildPass();
    int i, rej, guard, j, yy, tmp;
    bit forced, take;
    exp_q.push_back(mk(1, 0, 0, 0, 1, 0));
    for (int k = 0; k < 8; k++) model_perm[k] = k;
    i = 7;
    rej = 0;
    guard = 0;
    while (i >= 1 && guard < 1000) begin
      guard++;
      j = int'(model_lfsr[2:0]);
      model_lfsr = model_step(model_lfsr);
      forced = BOUNDED && (rej == 4);
      take = forced || (j <= i);
      if (take) begin
        yy = forced ? i : j;
        exp_q.push_back(mk(0, 1, i, yy, 1, 0));
        tmp = model_perm[i];
        model_perm[i] = model_perm[yy];
        model_perm[yy] = tmp;
        i--;
        rej = 0;
      end else begin
        exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
        rej++;
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
  endtask

  // Per-cycle compare against the model, plus downstream permutation register.
  always @(negedge clk) begin
    rec_t act, expv;
    int tmp;
    act = {init, swapxy, x, y, busy, done};
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checkOutput("cycle outputs", int'(act), int'(expv));
    if (init) for (int k = 0; k < 8; k++) dut_perm[k] = k;
    if (swapxy) begin
      swap_log.push_back(int'({x, y}));
      tmp = dut_perm[x];
      dut_perm[x] = dut_perm[y];
      dut_perm[y] = tmp;
    end
    if (done) done_count++;
    if (busy && !init && !swapxy) reject_count++;
  end

  task automatic applyStimulus(bit do_start, bit do_load, logic [7:0] s);
    bit idle_now;
    @(posedge clk);
    #2;
    idle_now = (exp_q.size() == 0) && rst_n;
    start = do_start;
    seed_load = do_load;
    seed = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    seed_load = 1'b0;
    if (idle_now) begin
      if (do_load) model_lfsr = (s == 8'h00) ? 8'h01 : s;
      if (do_start) buildPass();
    end
  endtask

  task automatic clearLog();
    swap_log.delete();
    done_count = 0;
    reject_count = 0;
  endtask

  task automatic waitIdle(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checkOutput({name, " pass finished"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
    checkOutput({name, " busy low after"}, int'(busy), 0);
  endtask

  task automatic doReset(int cycles);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    model_lfsr = 8'h01;
    #1;
    checkOutput("async reset outputs", int'({init, swapxy, x, y, busy, done}), 0);
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic checkPass(string name, int rejects);
    int cnt;
    checkOutput({name, " swap count"}, swap_log.size(), 7);
    checkOutput({name, " done count"}, done_count, 1);
    if (rejects >= 0) checkOutput({name, " reject count"}, reject_count, rejects);
    for (int v = 0; v < 8; v++) begin
      cnt = 0;
      for (int k = 0; k < 8; k++) if (dut_perm[k] == v) cnt++;
      checkOutput({name, " perm value once"}, cnt, 1);
      checkOutput({name, " perm vs model"}, dut_perm[v], model_perm[v]);
    end
  endtask

  task automatic checkLiterals(string name);
    int a;
    for (int k = 0; k < 7; k++) begin
      a = (k < swap_log.size()) ? swap_log[k] : -1;
      checkOutput({name, " literal swap"}, a, lit[k]);
    end
  endtask

  initial begin
    lit[0] = (7 << 3) | 1;
    lit[1] = (6 << 3) | 2;
    lit[2] = (5 << 3) | 4;
    lit[3] = (4 << 3) | 0;
    lit[4] = (3 << 3) | 1;
    lit[5] = BOUNDED ? ((2 << 3) | 2) : ((2 << 3) | 0);
    lit[6] = (1 << 3) | 1;
    for (int k = 0; k < 8; k++) dut_perm[k] = k;

    #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset state", int'({init, swapxy, x, y, busy, done}), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Default seed pass: fixed sequence with four rejections at i=2.
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitIdle("default seed");
    checkLiterals("default seed");
    checkPass("default seed", 4);

    // Continuing LFSR; start and seed_load pulsed mid-pass must be ignored.
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    waitIdle("ignored start");
    checkPass("ignored start", -1);

    // Zero seed maps to 8'h01 and reproduces the default sequence.
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitIdle("zero seed");
    checkLiterals("zero seed");
    checkPass("zero seed", 4);

    // seed_load and start in the same cycle both take effect.
    clearLog();
    applyStimulus(1'b1, 1'b1, 8'hA5);
    waitIdle("seed A5");
    checkPass("seed A5", -1);

    // Reset in the middle of SWAP abandons the pass without a done pulse.
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    repeat (4) @(posedge clk);
    doReset(2);
    repeat (3) @(posedge clk);
    checkOutput("no done after mid reset", done_count, 0);
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    waitIdle("after reset");
    checkLiterals("after reset");
    checkPass("after reset", 4);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
